fp_adder_arbiter: RTL and testbench
===================================

Name: fp_adder_arbiter

Overview:
Round-robin arbiter that shares one pipelined single-precision floating-point adder/subtractor (fixed LATENCY, always enabled) among NREQ requesters.
- Grants at most one operation per clock and registers the winner's operands into the adder.
- Tracks each in-flight operation's owner through a tag pipeline.
- Returns each result on a shared result bus with a per-requester done pulse.
- Sits between the solver math-stage controllers and the single Adder_nodsp instance, replacing one-adder-per-controller duplication.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width (`SINGLE)
LATENCY, 7, adder pipeline depth in clocks, operands-in to result-out

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
req  input  NREQ  per-requester operation request, level, held until granted
add_sub_in  input  NREQ  per-requester op select: 1 = add, 0 = subtract (x - y)
x_in  input  NREQ*WIDTH  packed operand x, requester i at bits [i*WIDTH +: WIDTH]
y_in  input  NREQ*WIDTH  packed operand y, same packing
gnt  output  NREQ  one-hot grant, combinational, same cycle as winning req
done  output  NREQ  one-hot registered pulse, result for that requester valid on xy_out
xy_out  output  WIDTH  registered result bus
busy  output  1  high while any operation is in flight
adder_sta  output  1  registered issue strobe to adder (diagnostic / downstream delay match)
adder_add_sub  output  1  registered op select to adder
adder_x  output  WIDTH  registered operand x to adder
adder_y  output  WIDTH  registered operand y to adder
adder_xy  input  WIDTH  adder result

Behaviour:
- Reset (rst = 0, async):
  - Outputs: gnt, done, xy_out, adder_sta, adder_add_sub, adder_x, adder_y, busy all 0.
  - Round-robin pointer cleared to 0; tag pipeline cleared.
  - Operations in flight at reset are discarded and produce no done. The first cycle after release behaves as idle.
- Arbitration (cycle t): search req starting at index ptr, wrapping modulo NREQ. First asserted index w wins; gnt = one-hot(w). No req means gnt = 0.
- Pointer: on grant, ptr <= (w + 1) mod NREQ at end of cycle t. With no grant, ptr holds. A requester asserting req continuously is served at least once every NREQ cycles.
- Requester rule: on seeing gnt[i] in cycle t, the requester may drop or change req/operands at t+1. A new request at t+1 competes normally.
- Issue (t+1): adder_x/adder_y/adder_add_sub hold requester w's values captured at t; adder_sta = 1 for one cycle. With no grant, adder_sta = 0 and operand registers hold their previous values.
- Tag pipeline: LATENCY+1 stages of {valid, index[clog2(NREQ)-1:0]}. Stage 0 loads {1, w} at t+1 or {0, x} when idle; shifts every cycle.
- Result (t+LATENCY+1): adder_xy is valid; the last tag stage carries the owner.
- Return (t+LATENCY+2): xy_out <= adder_xy and done[index] = 1 for exactly one cycle when the last stage is valid. Otherwise done = 0 and xy_out holds.
- Latency: gnt to done is exactly LATENCY+2 clocks.
- Throughput: one op per clock sustained. Back-to-back grants yield back-to-back done pulses in grant order, possibly to the same requester.
- busy = OR of all tag valid bits OR adder_sta.
- Simultaneous requests: exactly one grant per cycle. Losers keep req and are granted later in pointer order.
- Single requester: granted every cycle it requests. Pointer moves past it; the wrap-around search still finds it.
- No arithmetic in this block. IEEE handling (NaN, denormal) belongs to the adder; results pass through unmodified.

Test Plan:
- Single op: req[0]=1 with x=0x3F800000, y=0x40000000, add_sub=1 for one cycle -> gnt[0] same cycle. adder_sta=1 next cycle. done[0] and xy_out=0x40400000 exactly 9 cycles after gnt. busy high throughout, low after.
- Subtract: req[2], x=0x40A00000, y=0x40400000, add_sub=0 -> done[2], xy_out=0x40000000 at 9 cycles.
- Contention: req=4'b1111 held with distinct operands, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles. Done pulses 0,1,2,3,0 on consecutive cycles, each with its own correct sum.
- Fairness/wrap: after granting 3, req=4'b1001 -> next grant 0, then 3, alternating. req=4'b0100 alone -> granted every cycle.
- Idle gaps: requests at cycles 0, 3, 4 -> done at 9, 12, 13 with matching owners. done=0 and xy_out stable in between.
- Reset mid-flight: 3 ops issued, rst low for 1 cycle at cycle 4 -> all outputs 0 immediately. No done pulses for the discarded ops. ptr=0 after release. A new req[1] completes normally 9 cycles after its grant.

Source files
------------

// File: rtl/fp_adder_arbiter_if.sv
// Requester-side bundle of the shared FP adder: requests and operands in, grants and results out.
// Purely structural; it adds no latency of its own.
// Requesters hold req until they see gnt; there is no backpressure on the result side.
interface fp_adder_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       add_sub_in;
  logic [NREQ*WIDTH-1:0] x_in;
  logic [NREQ*WIDTH-1:0] y_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      xy_out;
  logic                  busy;

  // Requester (controller) side
  modport master (
    output req, add_sub_in, x_in, y_in,
    input  gnt, done, xy_out, busy
  );

  // Arbiter side
  modport slave (
    input  req, add_sub_in, x_in, y_in,
    output gnt, done, xy_out, busy
  );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin share of one pipelined FP adder among NREQ requesters, with an owner-tag pipeline.
// The grant is combinational; the done pulse and xy_out follow the grant by exactly LATENCY+2 clocks.
// Losing requesters hold req until granted; one issue per clock, and results are never stalled.
module fp_adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 7
) (
  input  logic             clk,
  input  logic             rst,
  fp_adder_arbiter_if.slave rq,
  output logic             adder_sta,
  output logic             adder_add_sub,
  output logic [WIDTH-1:0] adder_x,
  output logic [WIDTH-1:0] adder_y,
  input  logic [WIDTH-1:0] adder_xy
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic             win_vld;
  logic [IDXW-1:0]  win_idx;
  logic [IDXW-1:0]  cand_idx;

  logic             sta_q, sta_d;
  logic             add_sub_q, add_sub_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [LATENCY:0] tag_vld_q, tag_vld_d;
  logic [IDXW-1:0]  tag_idx_q [LATENCY+1];
  logic [IDXW-1:0]  tag_idx_d [LATENCY+1];

  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] xy_q, xy_d;

  // Round-robin search starting at ptr; gnt is forced low while reset is held
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_idx = IDXW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && rq.req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
    rq.gnt = '0;
    if (win_vld && rst) begin
      rq.gnt = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end
  end

  // Next pointer, issue registers, tag shift and result return
  always_comb begin
    ptr_d     = ptr_q;
    sta_d     = win_vld;
    add_sub_d = add_sub_q;
    x_d       = x_q;
    y_d       = y_q;
    if (win_vld) begin
      ptr_d = (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (win_idx == IDXW'(i)) begin
          add_sub_d = rq.add_sub_in[i];
          x_d       = rq.x_in[i*WIDTH +: WIDTH];
          y_d       = rq.y_in[i*WIDTH +: WIDTH];
        end
      end
    end

    // Stage 0 lines up with the issue strobe; stage LATENCY lines up with adder_xy
    tag_vld_d    = {tag_vld_q[LATENCY-1:0], win_vld};
    tag_idx_d[0] = win_idx;
    for (int s = 1; s <= LATENCY; s++) begin
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    done_d = '0;
    xy_d   = xy_q;
    if (tag_vld_q[LATENCY]) begin
      done_d = {{(NREQ-1){1'b0}}, 1'b1} << tag_idx_q[LATENCY];
      xy_d   = adder_xy;
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      sta_q     <= 1'b0;
      add_sub_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
      done_q    <= '0;
      xy_q      <= '0;
    end else begin
      ptr_q     <= ptr_d;
      sta_q     <= sta_d;
      add_sub_q <= add_sub_d;
      x_q       <= x_d;
      y_q       <= y_d;
      tag_vld_q <= tag_vld_d;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
      done_q    <= done_d;
      xy_q      <= xy_d;
    end
  end

  assign adder_sta     = sta_q;
  assign adder_add_sub = add_sub_q;
  assign adder_x       = x_q;
  assign adder_y       = y_q;
  assign rq.done       = done_q;
  assign rq.xy_out     = xy_q;
  assign rq.busy       = (|tag_vld_q) | sta_q;
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter with a table-driven LATENCY-deep adder model.
// Grant checks happen right after inputs change; done/xy_out are scoreboarded every cycle.
// Requests are driven on the falling edge and released after the grant is seen.
module tb_fp_adder_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 7;

  logic clk;
  logic rst;
  logic adder_sta, adder_add_sub;
  logic [W-1:0] adder_x, adder_y, adder_xy;

  fp_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) rq ();

  fp_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rq           (rq),
    .adder_sta    (adder_sta),
    .adder_add_sub(adder_add_sub),
    .adder_x      (adder_x),
    .adder_y      (adder_y),
    .adder_xy     (adder_xy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed per-requester operands: 1+2, 2+2, 5-3, 2-1
  logic [W-1:0] op_x [NREQ];
  logic [W-1:0] op_y [NREQ];
  logic         op_a [NREQ];
  initial begin
    op_x[0] = 32'h3F800000; op_y[0] = 32'h40000000; op_a[0] = 1'b1;
    op_x[1] = 32'h40000000; op_y[1] = 32'h40000000; op_a[1] = 1'b1;
    op_x[2] = 32'h40A00000; op_y[2] = 32'h40400000; op_a[2] = 1'b0;
    op_x[3] = 32'h40000000; op_y[3] = 32'h3F800000; op_a[3] = 1'b0;
  end
  assign rq.x_in       = {op_x[3], op_x[2], op_x[1], op_x[0]};
  assign rq.y_in       = {op_y[3], op_y[2], op_y[1], op_y[0]};
  assign rq.add_sub_in = {op_a[3], op_a[2], op_a[1], op_a[0]};

  // Hand-computed single-precision results for the operand pairs used here
  function automatic logic [W-1:0] fmodel(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic a);
    case ({a, x, y})
      {1'b1, 32'h3F800000, 32'h40000000}: fmodel = 32'h40400000; // 1+2=3
      {1'b1, 32'h40000000, 32'h40000000}: fmodel = 32'h40800000; // 2+2=4
      {1'b0, 32'h40A00000, 32'h40400000}: fmodel = 32'h40000000; // 5-3=2
      {1'b0, 32'h40000000, 32'h3F800000}: fmodel = 32'h3F800000; // 2-1=1
      default:                            fmodel = 32'hDEADBEEF;
    endcase
  endfunction

  // Adder stand-in: LAT register stages from registered operands to adder_xy
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fmodel(adder_x, adder_y, adder_add_sub);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign adder_xy = pipe[LAT-1];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  logic [W-1:0]    exp_xy = '0;
  logic [NREQ-1:0] exp_done [int];
  logic [W-1:0]    exp_val  [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expect a done for grant mask g exactly LAT+2 cycles from now
  task automatic sched(input logic [NREQ-1:0] g);
    int idx;
    idx = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
    exp_done[cyc + LAT + 2] = g;
    exp_val[cyc + LAT + 2]  = fmodel(op_x[idx], op_y[idx], op_a[idx]);
  endtask

  task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ-1:0] eg);
    @(negedge clk);
    rq.req = r;
    #1;
    chk("gnt", {28'd0, rq.gnt}, {28'd0, eg});
    if (eg != '0) sched(eg);
  endtask

  // Result-side scoreboard, sampled shortly after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (exp_done.exists(cyc)) begin
          chk("done", {28'd0, rq.done}, {28'd0, exp_done[cyc]});
          chk("xy_out", rq.xy_out, exp_val[cyc]);
          exp_xy = exp_val[cyc];
          exp_done.delete(cyc);
          exp_val.delete(cyc);
        end else begin
          chk("done_idle", {28'd0, rq.done}, 32'd0);
          chk("xy_hold", rq.xy_out, exp_xy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    rq.req = '0;
    repeat (3) @(negedge clk);
    rq.req = 4'b0001;
    #1;
    chk("rst_gnt", {28'd0, rq.gnt}, 32'd0);
    chk("rst_done", {28'd0, rq.done}, 32'd0);
    chk("rst_busy", {31'd0, rq.busy}, 32'd0);
    chk("rst_sta", {31'd0, adder_sta}, 32'd0);
    chk("rst_x", adder_x, 32'd0);
    chk("rst_xy", rq.xy_out, 32'd0);
    @(negedge clk);
    rq.req = '0;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Single add on requester 0
    issue(4'b0001, 4'b0001);
    @(negedge clk);
    rq.req = '0;
    #1;
    chk("issue_sta", {31'd0, adder_sta}, 32'd1);
    chk("issue_x", adder_x, 32'h3F800000);
    chk("issue_y", adder_y, 32'h40000000);
    chk("issue_op", {31'd0, adder_add_sub}, 32'd1);
    chk("busy_early", {31'd0, rq.busy}, 32'd1);
    @(negedge clk);
    #1;
    chk("sta_pulse", {31'd0, adder_sta}, 32'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("busy_late", {31'd0, rq.busy}, 32'd1);
    @(negedge clk);
    #1;
    chk("busy_off", {31'd0, rq.busy}, 32'd0);

    // Subtract on requester 2 (ptr=1), then requester 3 brings ptr back to 0
    issue(4'b0100, 4'b0100);
    repeat (10) issue(4'b0000, 4'b0000);
    issue(4'b1000, 4'b1000);
    issue(4'b0000, 4'b0000);

    // Contention with all four held: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) issue(4'b1111, 4'(1 << (i % 4)));
    // Wrap-around fairness between 0 and 3
    for (int i = 0; i < 4; i++) issue(4'b1001, (i % 2 == 0) ? 4'b0001 : 4'b1000);
    // Lone requester granted every cycle
    repeat (3) issue(4'b0100, 4'b0100);
    repeat (10) issue(4'b0000, 4'b0000);

    // Idle gaps: grants at relative cycles 0, 3, 4 (ptr=3 at start)
    issue(4'b0010, 4'b0010);
    repeat (2) issue(4'b0000, 4'b0000);
    issue(4'b1000, 4'b1000);
    issue(4'b0001, 4'b0001);
    repeat (12) issue(4'b0000, 4'b0000);

    // Reset mid-flight: three ops issued (ptr=1 at start), reset at relative cycle 4
    issue(4'b0111, 4'b0010);
    issue(4'b0111, 4'b0100);
    issue(4'b0111, 4'b0001);
    issue(4'b0000, 4'b0000);
    @(negedge clk);
    rst    = 1'b0;
    rq.req = 4'b1110;
    exp_done.delete();
    exp_val.delete();
    exp_xy = '0;
    #1;
    chk("mid_gnt", {28'd0, rq.gnt}, 32'd0);
    chk("mid_done", {28'd0, rq.done}, 32'd0);
    chk("mid_xy", rq.xy_out, 32'd0);
    chk("mid_sta", {31'd0, adder_sta}, 32'd0);
    chk("mid_op", {31'd0, adder_add_sub}, 32'd0);
    chk("mid_x", adder_x, 32'd0);
    chk("mid_y", adder_y, 32'd0);
    chk("mid_busy", {31'd0, rq.busy}, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    rq.req = '0;
    #1;
    chk("post_gnt", {28'd0, rq.gnt}, 32'd0);
    // ptr=0 picks requester 1 out of {1,2,3}; a stale ptr of 1 would too, 3 would not
    issue(4'b1110, 4'b0010);
    repeat (12) issue(4'b0000, 4'b0000);
    chk("sched_empty", exp_done.num(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
